// File: rtl/emif_loader_pkg.sv
// emif_buffer_loader shared types and sizing helpers.
// Optional checksum output is enabled with LOAD_CHECKSUM_EN.
package emif_loader_pkg;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_FETCH,
    LD_UNPACK,
    LD_DONE
  } ld_state_e;

  function automatic int calc_ratio(input int ew, input int bw);
    return ew / bw;
  endfunction

  function automatic int calc_dest_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/emif_buffer_loader_unpacker.sv
// word_unpacker: holds one EMIF word and emits its buffer-width slices,
// least-significant first, from a registered slice output.
module word_unpacker
  import emif_loader_pkg::*;
#(
  parameter int EW = 128,
  parameter int BW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          advance,
  input  logic [EW-1:0] word_in,
  output logic [BW-1:0] slice,
  output logic          last
);

  localparam int RATIO = calc_ratio(EW, BW);
  localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [EW-1:0] word_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_nxt;
  logic [BW-1:0] slice_q;

  assign idx_nxt = idx_q + IW'(1);
  assign last    = (idx_q == IW'(RATIO - 1));
  assign slice   = slice_q;

  // Slice 0 is presented straight from the incoming word on capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      idx_q   <= '0;
      slice_q <= '0;
    end else if (load) begin
      word_q  <= word_in;
      idx_q   <= '0;
      slice_q <= word_in[BW-1:0];
    end else if (advance) begin
      idx_q   <= idx_nxt;
      slice_q <= word_q[int'(idx_nxt)*BW +: BW];
    end
  end

endmodule

// File: rtl/emif_buffer_loader.sv
// emif_buffer_loader: copies EMIF words into a selected ML buffer,
// narrowing each word into slices. LOAD_CHECKSUM_EN adds checksum.
module emif_buffer_loader
  import emif_loader_pkg::*;
#(
  parameter int EMIF_ADDR_WIDTH = 12,
  parameter int EMIF_DATA_WIDTH = 128,
  parameter int BUF_ADDR_WIDTH  = 8,
  parameter int BUF_DATA_WIDTH  = 32,
  parameter int NUM_BUFS        = 2,
  parameter int READ_LATENCY    = 0,
  localparam int DEST_W = calc_dest_w(NUM_BUFS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [EMIF_ADDR_WIDTH-1:0] base_addr,
  input  logic [BUF_ADDR_WIDTH-1:0]  buf_base,
  input  logic [BUF_ADDR_WIDTH:0]    num_words,
  input  logic [DEST_W-1:0]          dest_sel,
  output logic                       busy,
  output logic                       done,
  output logic [EMIF_ADDR_WIDTH-1:0] emif_address,
  input  logic [EMIF_DATA_WIDTH-1:0] emif_dataout,
  output logic                       emif_wen,
  output logic [BUF_ADDR_WIDTH-1:0]  buf_addr,
  output logic [BUF_DATA_WIDTH-1:0]  buf_datain,
  output logic [NUM_BUFS-1:0]        buf_we
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [BUF_DATA_WIDTH-1:0]  checksum
`endif
);

  localparam int CW = BUF_ADDR_WIDTH + 1;

  ld_state_e          state;
  logic [1:0]         fcnt;
  logic [CW-1:0]      rem;
  logic [DEST_W-1:0]  dest;
  logic               load;
  logic               advance;
  logic               last;
  logic               accept;

  assign emif_wen = 1'b0;
  assign accept   = start &&
                    (state == LD_IDLE || state == LD_DONE);
  assign load     = (state == LD_FETCH) &&
                    (fcnt == 2'(READ_LATENCY));
  assign advance  = (state == LD_UNPACK) &&
                    (rem != CW'(1)) && !last;

  word_unpacker #(
    .EW(EMIF_DATA_WIDTH),
    .BW(BUF_DATA_WIDTH)
  ) u_unpack (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .advance(advance),
    .word_in(emif_dataout),
    .slice  (buf_datain),
    .last   (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LD_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      buf_we       <= '0;
      emif_address <= '0;
      buf_addr     <= '0;
      fcnt         <= '0;
      rem          <= '0;
      dest         <= '0;
    end else begin
      unique case (state)
        LD_IDLE, LD_DONE: begin
          if (start) begin
            emif_address <= base_addr;
            buf_addr     <= buf_base;
            rem          <= num_words;
            dest         <= dest_sel;
            fcnt         <= '0;
            if (num_words == '0) begin
              state <= LD_DONE;
              done  <= 1'b1;
            end else begin
              state <= LD_FETCH;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        LD_FETCH: begin
          if (load) begin
            state  <= LD_UNPACK;
            buf_we <= NUM_BUFS'(1) << dest;
          end else begin
            fcnt <= fcnt + 2'd1;
          end
        end
        LD_UNPACK: begin
          buf_addr <= buf_addr + BUF_ADDR_WIDTH'(1);
          rem      <= rem - CW'(1);
          // Count exhaustion wins over end-of-word: partial words end here.
          if (rem == CW'(1)) begin
            state  <= LD_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            buf_we <= '0;
          end else if (last) begin
            state        <= LD_FETCH;
            emif_address <= emif_address + EMIF_ADDR_WIDTH'(1);
            fcnt         <= '0;
            buf_we       <= '0;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

`ifdef LOAD_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (|buf_we) begin
      checksum <= checksum ^ buf_datain;
    end
  end
`endif

endmodule

// File: tb/tb_emif_buffer_loader.sv
// Bench for emif_buffer_loader: two instances (latency 0 and 2)
// checked every cycle against a per-transfer expected timeline.
module tb_emif_buffer_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start;
  logic [11:0]  base_addr;
  logic [7:0]   buf_base;
  logic [8:0]   num_words;
  logic [0:0]   dest_sel;

  logic         busy0, done0, wen0;
  logic [11:0]  ea0;
  logic [7:0]   ba0;
  logic [31:0]  bd0;
  logic [1:0]   we0;
  logic [127:0] dout0;

  logic         busy2, done2, wen2;
  logic [11:0]  ea2;
  logic [7:0]   ba2;
  logic [31:0]  bd2;
  logic [1:0]   we2;
  logic [127:0] dout2;

`ifdef LOAD_CHECKSUM_EN
  logic [31:0]  ck0, ck2;
`endif

  logic [127:0] mem [4096];
  logic [127:0] p1, p2;

  assign dout0 = mem[ea0];
  always @(posedge clk) begin
    p1 <= mem[ea2];
    p2 <= p1;
  end
  assign dout2 = p2;

  emif_buffer_loader #(.READ_LATENCY(0)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .buf_base(buf_base),
    .num_words(num_words), .dest_sel(dest_sel),
    .busy(busy0), .done(done0), .emif_address(ea0),
    .emif_dataout(dout0), .emif_wen(wen0),
    .buf_addr(ba0), .buf_datain(bd0), .buf_we(we0)
`ifdef LOAD_CHECKSUM_EN
    , .checksum(ck0)
`endif
  );

  emif_buffer_loader #(.READ_LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .buf_base(buf_base),
    .num_words(num_words), .dest_sel(dest_sel),
    .busy(busy2), .done(done2), .emif_address(ea2),
    .emif_dataout(dout2), .emif_wen(wen2),
    .buf_addr(ba2), .buf_datain(bd2), .buf_we(we2)
`ifdef LOAD_CHECKSUM_EN
    , .checksum(ck2)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        busy, done, wr, fe;
    logic [1:0]  we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [11:0] ea;
  } exp_t;

  exp_t        q0[$], q2[$];
  logic        md0 = 1'b0, md2 = 1'b0;
  logic [31:0] mck0, mck2;
  logic        cmp_en = 1'b0;

  // Expected cycle-by-cycle timeline from cycle 1 after an accepted start.
  task automatic plan(input int which, input int lat,
                      input logic [11:0] b, input logic [7:0] bb,
                      input int n, input int d);
    exp_t e;
    logic [127:0] w;
    logic [31:0] ck;
    int wr;
    int words;
    ck = 0;
    wr = 0;
    words = (n + 3) / 4;
    for (int i = 0; i < words; i++) begin
      w = mem[b + 12'(i)];
      for (int c = 0; c <= lat; c++) begin
        e = '{default: 0};
        e.busy = 1; e.fe = 1; e.ea = b + 12'(i);
        if (which == 0) q0.push_back(e); else q2.push_back(e);
      end
      for (int k = 0; k < 4; k++) begin
        if (wr < n) begin
          e = '{default: 0};
          e.busy = 1; e.wr = 1;
          e.we = (d < 2) ? 2'(1 << d) : 2'b00;
          e.addr = bb + 8'(wr);
          e.data = w[k*32 +: 32];
          if (d < 2) ck = ck ^ e.data;
          if (which == 0) q0.push_back(e); else q2.push_back(e);
          wr++;
        end
      end
    end
    e = '{default: 0};
    e.done = 1;
    if (which == 0) begin q0.push_back(e); mck0 = ck; end
    else begin q2.push_back(e); mck2 = ck; end
  endtask

  task automatic cmpd(input string t, input exp_t e,
                      input logic b, input logic dn,
                      input logic [1:0] w, input logic [7:0] a,
                      input logic [31:0] dt, input logic [11:0] ea,
                      input logic wen);
    chk({t, ".busy"}, b, e.busy);
    chk({t, ".done"}, dn, e.done);
    chk({t, ".buf_we"}, w, e.we);
    chk({t, ".emif_wen"}, wen, 1'b0);
    if (e.wr) begin
      chk({t, ".buf_addr"}, a, e.addr);
      chk({t, ".buf_datain"}, dt, e.data);
    end
    if (e.fe) chk({t, ".emif_address"}, ea, e.ea);
  endtask

  logic [31:0] bufm0 [256];
  logic [31:0] bufm1 [256];
  int bc0 = 0, bc2 = 0, wc0 = 0;
  logic we1_seen = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      if (q0.size() > 0) begin
        e = q0.pop_front(); md0 = e.done;
      end else begin
        e = '{default: 0}; e.done = md0;
      end
      cmpd("l0", e, busy0, done0, we0, ba0, bd0, ea0, wen0);
      if (q2.size() > 0) begin
        e = q2.pop_front(); md2 = e.done;
      end else begin
        e = '{default: 0}; e.done = md2;
      end
      cmpd("l2", e, busy2, done2, we2, ba2, bd2, ea2, wen2);
      if (we0[0]) bufm0[ba0] = bd0;
      if (we0[1]) begin bufm1[ba0] = bd0; we1_seen = 1'b1; end
      if (|we0) wc0++;
      if (busy0) bc0++;
      if (busy2) bc2++;
    end
  end

  task automatic go(input logic [11:0] b, input logic [7:0] bb,
                    input int n, input int d);
    @(negedge clk); #1;
    base_addr = b; buf_base = bb;
    num_words = 9'(n); dest_sel = 1'(d); start = 1'b1;
    plan(0, 0, b, bb, n, d);
    plan(1, 2, b, bb, n, d);
    bc0 = 0; bc2 = 0; wc0 = 0; we1_seen = 1'b0;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((q0.size() > 0 || q2.size() > 0) && t < 300) begin
      @(negedge clk); #2;
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL timeout act=%0d exp=<300", t);
    end
`ifdef LOAD_CHECKSUM_EN
    chk("checksum_l0", ck0, mck0);
    chk("checksum_l2", ck2, mck2);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout act=expired exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h010] = 128'h44444444_33333333_22222222_11111111;
    mem[12'h011] = 128'h88888888_77777777_66666666_55555555;
    mem[12'h020] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    mem[12'hFFF] = 128'h0000000D_0000000C_0000000B_0000000A;
    mem[12'h000] = 128'h00000004_00000003_00000002_00000001;
    reset = 1'b1; start = 1'b0;
    base_addr = '0; buf_base = '0; num_words = '0; dest_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy0, 1'b0);
    chk("rst.done", done0, 1'b0);
    chk("rst.buf_we", we0, 2'b00);
    chk("rst.emif_address", ea0, 12'h000);
    chk("rst.buf_addr", ba0, 8'h00);
    chk("rst.buf_datain", bd0, 32'h0);
    chk("rst.emif_wen", wen0, 1'b0);
    reset = 1'b0;
    cmp_en = 1'b1;

    go(12'h010, 8'h00, 4, 0);
    wait_done();
    chk("basic.busy_l0", bc0, 5);
    chk("basic.busy_l2", bc2, 7);
    chk("basic.buf0_0", bufm0[0], 32'h11111111);
    chk("basic.buf0_3", bufm0[3], 32'h44444444);
    chk("basic.we1_never", we1_seen, 1'b0);
`ifdef LOAD_CHECKSUM_EN
    chk("basic.checksum", ck0, 32'h44444444);
`endif

    for (int i = 0; i < 256; i++) bufm1[i] = 32'hDEADBEEF;
    go(12'h010, 8'h00, 6, 1);
    wait_done();
    chk("partial.busy_l0", bc0, 8);
    chk("partial.buf1_4", bufm1[4], 32'h55555555);
    chk("partial.buf1_5", bufm1[5], 32'h66666666);
    chk("partial.buf1_6", bufm1[6], 32'hDEADBEEF);

    go(12'h020, 8'hFE, 4, 0);
    wait_done();
    chk("wrap.buf0_fe", bufm0[8'hFE], 32'hAAAAAAAA);
    chk("wrap.buf0_ff", bufm0[8'hFF], 32'hBBBBBBBB);
    chk("wrap.buf0_01", bufm0[8'h01], 32'hDDDDDDDD);

    go(12'h010, 8'h00, 8, 0);
    wait_done();
    chk("lat.busy_l2", bc2, 14);
    chk("lat.busy_l0", bc0, 10);
    chk("lat.buf0_7", bufm0[7], 32'h88888888);

    go(12'hFFF, 8'h10, 8, 1);
    wait_done();
    chk("ewrap.buf1_13", bufm1[8'h13], 32'h0000000D);
    chk("ewrap.buf1_14", bufm1[8'h14], 32'h00000001);

    go(12'h010, 8'h00, 0, 0);
    wait_done();
    chk("zero.writes", wc0, 0);
    chk("zero.busy", bc0, 0);

    go(12'h010, 8'h40, 8, 1);
    @(negedge clk); #1;
    start = 1'b1; base_addr = 12'h011;
    num_words = 9'd1; dest_sel = 1'b0;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done();
    chk("ignore.writes", wc0, 8);
    chk("ignore.buf1_47", bufm1[8'h47], 32'h88888888);

    go(12'h010, 8'h80, 8, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid.pre_we", we0, 2'b01);
    reset = 1'b1;
    #1;
    q0.delete(); q2.delete();
    md0 = 1'b0; md2 = 1'b0;
    chk("rstmid.we_l0", we0, 2'b00);
    chk("rstmid.we_l2", we2, 2'b00);
    chk("rstmid.busy", busy0, 1'b0);
    chk("rstmid.done", done0, 1'b0);
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rstmid.writes", wc0, 2);
    chk("rstmid.done_after", done0, 1'b0);

    go(12'h011, 8'h90, 4, 1);
    wait_done();
    chk("restart.busy", bc0, 5);
    chk("restart.buf1_93", bufm1[8'h93], 32'h88888888);
`ifdef LOAD_CHECKSUM_EN
    chk("restart.checksum", ck0, 32'hCCCCCCCC);
`endif

    repeat (2) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
